// File: rtl/restoring_div8x4.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, with a
// start/busy/done handshake and registered quotient, remainder and divide-by-zero flag.
module restoring_div8x4 #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
  input  logic          start,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic          busy,
  output logic          done
);

  localparam int IW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] a_lat;
  logic [VW-1:0] b_lat;
  logic [DW-1:0] q;
  logic [VW:0]   r;
  logic [IW-1:0] idx;
  logic [VW+1:0] step;

  // Returns {quotient bit, next partial remainder}. One guard bit above VW is
  // enough because the partial remainder never exceeds 2*divisor-1.
  function automatic logic [VW+1:0] div_step(input logic [VW:0]   r_in,
                                             input logic          bit_in,
                                             input logic [VW-1:0] d);
    logic [VW:0] r_shift;
    r_shift = {r_in[VW-1:0], bit_in};
    if (r_shift >= {1'b0, d})
      return {1'b1, r_shift - {1'b0, d}};
    else
      return {1'b0, r_shift};
  endfunction

  assign step = div_step(r, a_lat[idx], b_lat);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      a_lat       <= '0;
      b_lat       <= '0;
      q           <= '0;
      r           <= '0;
      idx         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_lat <= a;
            b_lat <= b;
            q     <= '0;
            r     <= '0;
            idx   <= IW'(DW - 1);
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          r      <= step[VW:0];
          q[idx] <= step[VW+1];
          if (idx == '0)
            state <= FIN;
          else
            idx <= idx - IW'(1);
        end
        FIN: begin
          // A zero divisor needs no special path: every trial subtract succeeds.
          quotient    <= q;
          remainder   <= r[VW-1:0];
          div_by_zero <= (b_lat == '0);
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
